// File: rtl/err_inject_pkg.sv
// Shared types and constants for the err_inject error-injection block.
// Holds the mode encoding and the Galois LFSR polynomial and width.
package err_inject_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_SINGLE = 2'd1,
      MODE_DOUBLE = 2'd2,
      MODE_RANDOM = 2'd3
   } mode_e;

   localparam int LFSR_W = 16;

   // x^16+x^14+x^13+x^11+1, right-shifting Galois form
   localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/err_lfsr.sv
// 16-bit Galois LFSR used for random error positions.
// Advances one step per cycle while i_adv is high.
module err_lfsr
   import err_inject_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_adv,
   output logic [LFSR_W-1:0] o_state
);

   logic [LFSR_W-1:0] r_state;
   logic [LFSR_W-1:0] w_next;

   assign w_next = {1'b0, r_state[LFSR_W-1:1]}
                 ^ (r_state[0] ? LFSR_POLY : '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SEED;
      end else if (i_adv) begin
         r_state <= w_next;
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/err_inject.sv
// Codeword error injector: flips fixed or random bits on every Nth word.
// Define ERR_INJECT_STATS_EN to build the word/bit statistics counters.
module err_inject
   import err_inject_pkg::*;
#(
   parameter int          CW_W      = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [1:0]               i_mode,
   input  logic [$clog2(CW_W)-1:0]  i_pos_a,
   input  logic [$clog2(CW_W)-1:0]  i_pos_b,
   input  logic [7:0]               i_period,
   input  logic                     i_valid,
   input  logic [CW_W-1:0]          i_data,
   output logic                     o_ready,
   output logic                     o_valid,
   output logic [CW_W-1:0]          o_data,
   output logic [CW_W-1:0]          o_err_mask,
   input  logic                     i_ready,
   output logic [15:0]              o_word_cnt,
   output logic [15:0]              o_bit_cnt
);

   mode_e             w_mode;
   logic              w_ready;
   logic              w_acc;
   logic              w_slot;
   logic [CW_W-1:0]   w_mask;
   logic [LFSR_W-1:0] w_lfsr;
   int                w_p1;
   int                w_p2;

   logic              r_valid;
   logic [CW_W-1:0]   r_data;
   logic [CW_W-1:0]   r_mask;
   logic [7:0]        r_pcnt;

   assign w_mode  = mode_e'(i_mode);
   assign w_ready = !r_valid || i_ready;
   assign w_acc   = i_valid && w_ready;
   assign w_slot  = (r_pcnt == i_period);

   err_lfsr #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_adv  (w_acc && (w_mode == MODE_RANDOM)),
      .o_state(w_lfsr)
   );

   // p2 is offset from p1 by 1..CW_W-1, so it can never alias p1
   always_comb begin
      w_mask = '0;
      w_p1   = int'(w_lfsr[7:0]) % CW_W;
      w_p2   = (w_p1 + 1 + int'(w_lfsr[14:8]) % (CW_W - 1)) % CW_W;
      for (int i = 0; i < CW_W; i++) begin
         unique case (w_mode)
            MODE_BYPASS: w_mask[i] = 1'b0;
            MODE_SINGLE: w_mask[i] = (int'(i_pos_a) == i);
            MODE_DOUBLE: w_mask[i] = (int'(i_pos_a) == i)
                                   || (int'(i_pos_b) == i);
            MODE_RANDOM: w_mask[i] = (w_p1 == i)
                                   || (w_lfsr[15] && (w_p2 == i));
         endcase
      end
      if (!w_slot) begin
         w_mask = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pcnt <= '0;
      end else if (w_acc) begin
         if ((w_mode == MODE_BYPASS) || w_slot) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_mask  <= '0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_data  <= i_data ^ w_mask;
         r_mask  <= w_mask;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_ready    = w_ready;
   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_err_mask = r_mask;

`ifdef ERR_INJECT_STATS_EN
   logic        w_emit;
   logic [15:0] w_pop;
   logic [16:0] w_bsum;
   logic [15:0] r_wcnt;
   logic [15:0] r_bcnt;

   assign w_emit = r_valid && i_ready && (|r_mask);

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < CW_W; i++) begin
         w_pop = w_pop + 16'(r_mask[i]);
      end
   end

   assign w_bsum = {1'b0, r_bcnt} + {1'b0, w_pop};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wcnt <= '0;
         r_bcnt <= '0;
      end else if (w_emit) begin
         if (r_wcnt != 16'hFFFF) begin
            r_wcnt <= r_wcnt + 16'd1;
         end
         r_bcnt <= w_bsum[16] ? 16'hFFFF : w_bsum[15:0];
      end
   end

   assign o_word_cnt = r_wcnt;
   assign o_bit_cnt  = r_bcnt;
`else
   assign o_word_cnt = '0;
   assign o_bit_cnt  = '0;
`endif

endmodule

// File: tb/tb_err_inject.sv
// Scoreboard bench for err_inject: directed vectors plus an LFSR model.
// Counter expectations follow ERR_INJECT_STATS_EN.
module tb_err_inject;

`ifdef ERR_INJECT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [15:0] SEED = 16'hACE1;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [1:0] i_mode;
   logic [2:0] i_pos_a;
   logic [2:0] i_pos_b;
   logic [7:0] i_period;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic [7:0] o_err_mask;
   logic       i_ready;
   logic [15:0] o_word_cnt;
   logic [15:0] o_bit_cnt;

   err_inject #(
      .CW_W     (8),
      .LFSR_SEED(SEED)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_mode    (i_mode),
      .i_pos_a   (i_pos_a),
      .i_pos_b   (i_pos_b),
      .i_period  (i_period),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_ready   (o_ready),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .o_err_mask(o_err_mask),
      .i_ready   (i_ready),
      .o_word_cnt(o_word_cnt),
      .o_bit_cnt (o_bit_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] d;
      logic [7:0] m;
      bit         rnd;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [15:0] mstate;
   int          exp_w;
   int          exp_b;

   always @(posedge i_clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   exp_t mon_e;
   int   mon_pc;
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got %0h want none", o_data);
         end else begin
            mon_e = q.pop_front();
            chk("data", 32'(o_data), 32'(mon_e.d));
            chk("mask", 32'(o_err_mask), 32'(mon_e.m));
            if (mon_e.rnd) begin
               mon_pc = $countones(o_err_mask);
               chk("rnd_pop", 32'((mon_pc == 1) || (mon_pc == 2)), 32'd1);
            end
         end
      end
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [7:0] rand_mask(input logic [15:0] s);
      int p1, p2;
      logic [7:0] m;
      p1 = int'(s[7:0]) % 8;
      m  = 8'(1 << p1);
      if (s[15]) begin
         p2 = (p1 + 1 + (int'(s[14:8]) % 7)) % 8;
         m  = m | 8'(1 << p2);
      end
      return m;
   endfunction

   task automatic drive(input logic [7:0] d, input logic [1:0] md,
                        input logic [2:0] pa, input logic [2:0] pb,
                        input logic [7:0] per, input logic [7:0] m,
                        input bit rnd);
      exp_t e;
      i_data   = d;
      i_mode   = md;
      i_pos_a  = pa;
      i_pos_b  = pb;
      i_period = per;
      i_valid  = 1'b1;
      e.d   = d ^ m;
      e.m   = m;
      e.rnd = rnd;
      q.push_back(e);
   endtask

   task automatic wait_acc();
      int n   = 0;
      bit acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge i_clk);
         acc = o_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      i_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got o_ready=0 want 1");
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] md,
                       input logic [2:0] pa, input logic [2:0] pb,
                       input logic [7:0] per, input logic [7:0] m,
                       input bit rnd);
      drive(d, md, pa, pb, per, m, rnd);
      wait_acc();
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || o_valid) && n < 200) begin
         @(posedge i_clk);
         n++;
      end
      #1;
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      q.delete();
      mstate = SEED;
   endtask

   task automatic chk_cnt(input string nm, input int w, input int b);
      chk({nm, "_wcnt"}, 32'(o_word_cnt), STATS ? 32'(w) : 32'd0);
      chk({nm, "_bcnt"}, 32'(o_bit_cnt), STATS ? 32'(b) : 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] m1 [6];
   logic [7:0] m3 [6];
   logic [7:0] mr;
   int         c0;

   initial begin
      m1 = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08};
      m3 = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00};
      i_rst_n  = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      i_mode   = 2'd0;
      i_pos_a  = 3'd0;
      i_pos_b  = 3'd0;
      i_period = 8'd0;
      i_data   = 8'd0;
      mstate   = SEED;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_mask", 32'(o_err_mask), 32'd0);
      chk_cnt("rst", 0, 0);
      i_rst_n = 1'b1;

      // bypass
      for (int i = 0; i < 4; i++) send(8'hA5, 2'd0, 3'd0, 3'd0, 8'd0, 8'h00, 1'b0);
      drain();
      chk_cnt("bypass", 0, 0);

      // single fixed, every third word
      for (int i = 0; i < 6; i++) send(8'h00, 2'd1, 3'd3, 3'd0, 8'd2, m1[i], 1'b0);
      drain();
      chk_cnt("single", 2, 2);

      // double fixed, then coincident positions
      send(8'hFF, 2'd2, 3'd0, 3'd6, 8'd0, 8'h41, 1'b0);
      send(8'hFF, 2'd2, 3'd5, 3'd5, 8'd0, 8'h20, 1'b0);
      drain();
      chk_cnt("double", 4, 5);

      // backpressure
      i_ready = 1'b0;
      send(8'h11, 2'd0, 3'd0, 3'd0, 8'd0, 8'h00, 1'b0);
      drive(8'h22, 2'd0, 3'd0, 3'd0, 8'd0, 8'h00, 1'b0);
      repeat (3) begin
         @(negedge i_clk);
         chk("stall_valid", 32'(o_valid), 32'd1);
         chk("stall_ready", 32'(o_ready), 32'd0);
         chk("stall_data", 32'(o_data), 32'h11);
      end
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      wait_acc();
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 2'd0, 3'd0, 3'd0, 8'd0, 8'h00, 1'b0);
      chk("full_rate", 32'(cyc - c0), 32'd8);
      drain();

      // random mode against the reference LFSR
      do_reset();
      exp_w = 0;
      exp_b = 0;
      for (int i = 0; i < 1000; i++) begin
         mr = rand_mask(mstate);
         send(8'(i * 7), 2'd3, 3'd0, 3'd0, 8'd0, mr, 1'b1);
         mstate = lfsr_next(mstate);
         exp_w++;
         exp_b += $countones(mr);
      end
      drain();
      chk_cnt("random", exp_w, exp_b);

      // reset mid-stream
      do_reset();
      for (int i = 0; i < 6; i++) send(8'h00, 2'd1, 3'd2, 3'd0, 8'd3, m3[i], 1'b0);
      drain();
      chk_cnt("pre_rst", 1, 1);
      i_ready = 1'b0;
      send(8'h00, 2'd1, 3'd2, 3'd0, 8'd3, 8'h00, 1'b0);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid), 32'd0);
      chk("arst_ready", 32'(o_ready), 32'd1);
      chk_cnt("arst", 0, 0);
      q.delete();
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(8'h00, 2'd1, 3'd2, 3'd0, 8'd3, m3[i], 1'b0);
      drain();
      chk_cnt("post_rst", 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
